// File: rtl/tournament_pkg.sv
// Shared types for the tournament choice-table controller: table ops, controller states,
// the in-flight prediction record and the choice-counter init value.
package tournament_pkg;

  localparam int unsigned HistWDefault = 12;

  typedef enum logic [1:0] {
    OpNop  = 2'b00,
    OpInc  = 2'b01,
    OpDec  = 2'b10,
    OpInit = 2'b11
  } tbl_op_e;

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic [HistWDefault-1:0] hist;
    logic                    lp;
    logic                    gp;
  } inflight_t;

  // Weakly-favour-global midpoint written by the init sweep.
  function automatic int unsigned choice_init_val(input int unsigned ctr_w);
    return 32'd1 << (ctr_w - 1);
  endfunction

endpackage

// File: rtl/choice_update_ctrl_if.sv
// Predictor-side and table-side signals of choice_update_ctrl; master = predictor/table side,
// slave = controller.
interface choice_update_ctrl_if #(
  parameter int unsigned HIST_W = 12
);
  logic              pred_valid;
  logic              pred_ready;
  logic [HIST_W-1:0] pred_hist;
  logic              lp_pred;
  logic              gp_pred;
  logic              resolve_valid;
  logic              resolve_taken;
  logic              flush;
  logic              tbl_we;
  logic [HIST_W-1:0] tbl_idx;
  logic [1:0]        tbl_op;
  logic              init_busy;
  logic              resolve_err;
  logic [15:0]       stat_gp_wins;
  logic [15:0]       stat_lp_wins;

  modport master (
    output pred_valid, pred_hist, lp_pred, gp_pred, resolve_valid, resolve_taken, flush,
    input  pred_ready, tbl_we, tbl_idx, tbl_op, init_busy, resolve_err,
    input  stat_gp_wins, stat_lp_wins
  );

  modport slave (
    input  pred_valid, pred_hist, lp_pred, gp_pred, resolve_valid, resolve_taken, flush,
    output pred_ready, tbl_we, tbl_idx, tbl_op, init_busy, resolve_err,
    output stat_gp_wins, stat_lp_wins
  );
endinterface

// File: rtl/tournament_inflight_fifo.sv
// In-flight prediction FIFO: push/pop/flush with full/empty and a combinational head.
// Flush empties after the same-cycle pop and discards a same-cycle push.
module tournament_inflight_fifo
  import tournament_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type payload_t = inflight_t
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     push,
  input  payload_t push_data,
  input  logic     pop,
  input  logic     flush,
  output payload_t head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  payload_t            mem_q [DEPTH];
  logic     [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic     [CntW-1:0] count_q;
  logic                push_ok, pop_ok;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  // A full FIFO rejects a push even when a pop frees a slot in the same cycle.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/choice_update_ctrl.sv
// Choice-table controller: post-reset INIT sweep, then one registered INC/DEC per resolved
// branch. Optional win counters are built only when CHOICE_STATS_EN is defined.
module choice_update_ctrl
  import tournament_pkg::*;
#(
  parameter int unsigned HIST_W = 12,
  parameter int unsigned CTR_W  = 3,
  parameter int unsigned DEPTH  = 4
) (
  input logic                clock,
  input logic                reset,
  choice_update_ctrl_if.slave bus
);

  if (CTR_W < 1 || CTR_W > 16) begin : g_bad_ctr_w
    $error("CTR_W must be in 1..16");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and >= 2");
  end

  // Same fields as inflight_t, sized to this instance's history width.
  typedef struct packed {
    logic [HIST_W-1:0] hist;
    logic              lp;
    logic              gp;
  } entry_t;

  ctrl_state_e       state_q, state_d;
  logic [HIST_W:0]   sweep_q, sweep_d;
  logic              tbl_we_q, tbl_we_d;
  logic [HIST_W-1:0] tbl_idx_q, tbl_idx_d;
  tbl_op_e           tbl_op_q, tbl_op_d;
  logic              err_q, err_d;

  entry_t  push_entry, head;
  logic    full, empty, run, upd_fire;
  tbl_op_e upd_op;

  assign run        = (state_q == StRun);
  assign push_entry = '{hist: bus.pred_hist, lp: bus.lp_pred, gp: bus.gp_pred};

  tournament_inflight_fifo #(
    .DEPTH     (DEPTH),
    .payload_t (entry_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (run && bus.pred_valid),
    .push_data (push_entry),
    .pop       (run && bus.resolve_valid),
    .flush     (run && bus.flush),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign upd_fire = run && bus.resolve_valid && !empty;

  always_comb begin
    upd_op = OpNop;
    if ((head.gp == bus.resolve_taken) && (head.lp != bus.resolve_taken)) begin
      upd_op = OpInc;
    end else if ((head.lp == bus.resolve_taken) && (head.gp != bus.resolve_taken)) begin
      upd_op = OpDec;
    end
  end

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    tbl_we_d  = 1'b0;
    tbl_idx_d = tbl_idx_q;
    tbl_op_d  = OpNop;
    err_d     = 1'b0;
    case (state_q)
      StInit: begin
        // The extra MSB marks "last index already issued"; leave on the following cycle.
        if (sweep_q[HIST_W]) begin
          state_d = StRun;
        end else begin
          tbl_we_d  = 1'b1;
          tbl_op_d  = OpInit;
          tbl_idx_d = sweep_q[HIST_W-1:0];
          sweep_d   = sweep_q + {{HIST_W{1'b0}}, 1'b1};
        end
      end
      StRun: begin
        if (bus.resolve_valid) begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            tbl_idx_d = head.hist;
            tbl_op_d  = upd_op;
            tbl_we_d  = (upd_op != OpNop);
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StInit;
      sweep_q   <= '0;
      tbl_we_q  <= 1'b0;
      tbl_idx_q <= '0;
      tbl_op_q  <= OpNop;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      tbl_we_q  <= tbl_we_d;
      tbl_idx_q <= tbl_idx_d;
      tbl_op_q  <= tbl_op_d;
      err_q     <= err_d;
    end
  end

  assign bus.pred_ready  = run && !full;
  assign bus.tbl_we      = tbl_we_q;
  assign bus.tbl_idx     = tbl_idx_q;
  assign bus.tbl_op      = tbl_op_q;
  assign bus.init_busy   = (state_q == StInit);
  assign bus.resolve_err = err_q;

`ifdef CHOICE_STATS_EN
  logic [15:0] gp_wins_q, lp_wins_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      gp_wins_q <= '0;
      lp_wins_q <= '0;
    end else if (upd_fire) begin
      if (upd_op == OpInc && gp_wins_q != 16'hFFFF) gp_wins_q <= gp_wins_q + 16'd1;
      if (upd_op == OpDec && lp_wins_q != 16'hFFFF) lp_wins_q <= lp_wins_q + 16'd1;
    end
  end

  assign bus.stat_gp_wins = gp_wins_q;
  assign bus.stat_lp_wins = lp_wins_q;
`else
  logic unused_fire;
  assign unused_fire      = upd_fire;
  assign bus.stat_gp_wins = '0;
  assign bus.stat_lp_wins = '0;
`endif

endmodule

// File: tb/tb_choice_update_ctrl.sv
// Bench for choice_update_ctrl (HIST_W=4, DEPTH=4): queue-based reference model checked every
// cycle, directed literal checks, then randomized traffic. Honours CHOICE_STATS_EN.
module tb_choice_update_ctrl;

  localparam int unsigned HW = 4;
  localparam int unsigned DP = 4;
`ifdef CHOICE_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  choice_update_ctrl_if #(.HIST_W(HW)) bus ();

  choice_update_ctrl #(
    .HIST_W (HW),
    .CTR_W  (3),
    .DEPTH  (DP)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [HW-1:0] hist;
    logic          lp;
    logic          gp;
  } ent_t;

  ent_t          q[$];
  ent_t          e;
  bit            m_init = 1'b1;
  int            m_cnt  = 0;
  int            sz;
  logic          ex_we  = 1'b0;
  logic [HW-1:0] ex_idx = '0;
  logic [1:0]    ex_op  = 2'd0;
  logic          ex_err = 1'b0;
  int            ex_gp  = 0;
  int            ex_lp  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1; m_cnt = 0; ex_we = 1'b0; ex_idx = '0; ex_op = 2'd0; ex_err = 1'b0;
      ex_gp = 0; ex_lp = 0;
      q.delete();
    end else if (m_init) begin
      ex_err = 1'b0;
      if (m_cnt == (1 << HW)) begin
        m_init = 1'b0; ex_we = 1'b0; ex_op = 2'd0;
      end else begin
        ex_we = 1'b1; ex_op = 2'd3; ex_idx = m_cnt[HW-1:0]; m_cnt++;
      end
    end else begin
      sz = q.size();
      ex_we = 1'b0; ex_op = 2'd0; ex_err = 1'b0;
      if (bus.resolve_valid) begin
        if (sz == 0) ex_err = 1'b1;
        else begin
          e = q.pop_front();
          if (e.gp == bus.resolve_taken && e.lp != bus.resolve_taken) ex_op = 2'd1;
          else if (e.lp == bus.resolve_taken && e.gp != bus.resolve_taken) ex_op = 2'd2;
          if (ex_op != 2'd0) begin
            ex_we = 1'b1; ex_idx = e.hist;
            if (ex_op == 2'd1 && ex_gp < 16'hFFFF) ex_gp++;
            if (ex_op == 2'd2 && ex_lp < 16'hFFFF) ex_lp++;
          end
        end
      end
      if (bus.flush) q.delete();
      else if (bus.pred_valid && sz < DP) q.push_back('{bus.pred_hist, bus.lp_pred, bus.gp_pred});
    end
  end

  always @(negedge clk) begin
    chk("init_busy", bus.init_busy, m_init);
    chk("pred_ready", bus.pred_ready, (!m_init && q.size() < DP));
    chk("tbl_we", bus.tbl_we, ex_we);
    chk("tbl_op", bus.tbl_op, ex_op);
    if (ex_we) chk("tbl_idx", bus.tbl_idx, ex_idx);
    chk("resolve_err", bus.resolve_err, ex_err);
    chk("stat_gp_wins", bus.stat_gp_wins, StatsOn ? ex_gp : 0);
    chk("stat_lp_wins", bus.stat_lp_wins, StatsOn ? ex_lp : 0);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [HW-1:0] h, input logic lp, input logic gp);
    bus.pred_valid = 1'b1; bus.pred_hist = h; bus.lp_pred = lp; bus.gp_pred = gp;
    cyc();
    bus.pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic t);
    bus.resolve_valid = 1'b1; bus.resolve_taken = t;
    cyc();
    bus.resolve_valid = 1'b0;
  endtask

  initial begin
    bus.pred_valid = 1'b0; bus.pred_hist = '0; bus.lp_pred = 1'b0; bus.gp_pred = 1'b0;
    bus.resolve_valid = 1'b0; bus.resolve_taken = 1'b0; bus.flush = 1'b0;
    rst = 1'b1;
    cyc(); cyc();
    chk("reset_busy", bus.init_busy, 1);
    chk("reset_ready", bus.pred_ready, 0);
    rst = 1'b0;

    // Init sweep, interrupted at index 7.
    cyc();
    chk("sweep_first_we", bus.tbl_we, 1);
    chk("sweep_first_op", bus.tbl_op, 2'b11);
    chk("sweep_first_idx", bus.tbl_idx, 0);
    repeat (7) cyc();
    chk("sweep_idx7", bus.tbl_idx, 7);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("midsweep_reset_we", bus.tbl_we, 0);
    cyc();
    chk("restart_idx", bus.tbl_idx, 0);
    chk("restart_we", bus.tbl_we, 1);
    repeat (15) cyc();
    chk("sweep_last_idx", bus.tbl_idx, 15);
    chk("sweep_last_busy", bus.init_busy, 1);
    cyc();
    chk("busy_drop", bus.init_busy, 0);
    chk("ready_after_init", bus.pred_ready, 1);
    chk("run_idle_we", bus.tbl_we, 0);

    // Stats: 3 INC then 2 DEC.
    for (int i = 0; i < 3; i++) begin push(4'h1, 1'b0, 1'b1); resolve(1'b1); end
    for (int i = 0; i < 2; i++) begin push(4'h2, 1'b1, 1'b0); resolve(1'b1); end
    chk("stats_gp_3", bus.stat_gp_wins, StatsOn ? 3 : 0);
    chk("stats_lp_2", bus.stat_lp_wins, StatsOn ? 2 : 0);

    // INC / DEC / NOP on a single entry.
    push(4'hA, 1'b1, 1'b0); resolve(1'b0);
    chk("inc_we", bus.tbl_we, 1); chk("inc_idx", bus.tbl_idx, 4'hA); chk("inc_op", bus.tbl_op, 1);
    push(4'hA, 1'b1, 1'b0); resolve(1'b1);
    chk("dec_we", bus.tbl_we, 1); chk("dec_op", bus.tbl_op, 2);
    push(4'hA, 1'b1, 1'b1); resolve(1'b1);
    chk("nop_we", bus.tbl_we, 0); chk("nop_op", bus.tbl_op, 0);

    // Fill, overflow attempt, drain in order.
    for (int i = 0; i < 4; i++) push(4'(i + 1), 1'b1, 1'b0);
    chk("full_ready", bus.pred_ready, 0);
    push(4'hF, 1'b1, 1'b0);
    chk("full_still", bus.pred_ready, 0);
    for (int i = 0; i < 4; i++) begin
      resolve(1'b0);
      chk("drain_idx", bus.tbl_idx, 4'(i + 1));
      chk("drain_op", bus.tbl_op, 1);
      if (i == 0) chk("ready_after_pop", bus.pred_ready, 1);
    end

    // Empty resolve.
    resolve(1'b0);
    chk("empty_err", bus.resolve_err, 1); chk("empty_we", bus.tbl_we, 0);
    cyc();
    chk("err_pulse_end", bus.resolve_err, 0);

    // Simultaneous push + pop at count 2.
    push(4'h3, 1'b1, 1'b0); push(4'h5, 1'b0, 1'b1);
    bus.pred_valid = 1'b1; bus.pred_hist = 4'h6; bus.lp_pred = 1'b1; bus.gp_pred = 1'b0;
    bus.resolve_valid = 1'b1; bus.resolve_taken = 1'b0;
    cyc();
    bus.pred_valid = 1'b0; bus.resolve_valid = 1'b0;
    chk("pp_idx", bus.tbl_idx, 4'h3); chk("pp_op", bus.tbl_op, 1);
    resolve(1'b0); chk("pp_2nd_idx", bus.tbl_idx, 4'h5); chk("pp_2nd_op", bus.tbl_op, 2);
    resolve(1'b0); chk("pp_3rd_idx", bus.tbl_idx, 4'h6); chk("pp_3rd_op", bus.tbl_op, 1);
    resolve(1'b0); chk("pp_drained_err", bus.resolve_err, 1);

    // Flush with same-cycle resolve and push.
    push(4'h7, 1'b1, 1'b0); push(4'h8, 1'b1, 1'b0); push(4'h9, 1'b1, 1'b0);
    bus.flush = 1'b1; bus.resolve_valid = 1'b1; bus.resolve_taken = 1'b0;
    bus.pred_valid = 1'b1; bus.pred_hist = 4'hC;
    cyc();
    bus.flush = 1'b0; bus.resolve_valid = 1'b0; bus.pred_valid = 1'b0;
    chk("flush_head_we", bus.tbl_we, 1); chk("flush_head_idx", bus.tbl_idx, 4'h7);
    resolve(1'b0);
    chk("flush_empty_err", bus.resolve_err, 1); chk("flush_empty_we", bus.tbl_we, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.pred_valid    = 1'($urandom_range(0, 1));
      bus.pred_hist     = 4'($urandom_range(0, 15));
      bus.lp_pred       = 1'($urandom_range(0, 1));
      bus.gp_pred       = 1'($urandom_range(0, 1));
      bus.resolve_valid = ($urandom_range(0, 2) != 0);
      bus.resolve_taken = 1'($urandom_range(0, 1));
      bus.flush         = ($urandom_range(0, 40) == 0);
      cyc();
    end
    bus.pred_valid = 1'b0; bus.resolve_valid = 1'b0; bus.flush = 1'b0;

    // Reset from run restarts the sweep.
    rst = 1'b1; cyc(); rst = 1'b0;
    cyc();
    chk("rerun_sweep_idx", bus.tbl_idx, 0); chk("rerun_sweep_op", bus.tbl_op, 2'b11);
    repeat (20) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/choice_update_ctrl.md
Name: choice_update_ctrl

Overview:
- Controller that sequences the tournament choice-counter table: runs the post-reset initialisation sweep, then tracks in-flight predictions and issues one table update per resolved branch.
- Sits between the fetch-side predictor lookup (local, global and choice outputs) and the 2^HIST_W x CTR_W choice table.
- Replaces ad-hoc delay-line alignment with an explicit in-flight FIFO, so resolve latency may vary.

Parameters:
HIST_W, 12, global-history / table index width
CTR_W, 3, choice counter width; init value = 1 << (CTR_W-1) (3'b100 at default)
DEPTH, 4, in-flight prediction FIFO entries (power of 2, >= 2)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
pred_valid  in  1  prediction issued this cycle
pred_ready  out  1  controller can accept prediction
pred_hist  in  HIST_W  global history used to index the choice table
lp_pred  in  1  local predictor direction
gp_pred  in  1  global predictor direction
resolve_valid  in  1  oldest in-flight branch resolved
resolve_taken  in  1  actual direction
flush  in  1  squash all in-flight entries
tbl_we  out  1  table write/op strobe
tbl_idx  out  HIST_W  table index
tbl_op  out  2  00 NOP, 01 INC (favor global), 10 DEC (favor local), 11 INIT (write init value)
init_busy  out  1  init sweep in progress
resolve_err  out  1  one-cycle pulse: resolve with empty FIFO
stat_gp_wins  out  16  see Optional Feature
stat_lp_wins  out  16  see Optional Feature

Behaviour:
- Reset: state=S_INIT, sweep_idx=0, FIFO empty. tbl_we=0, tbl_idx=0, tbl_op=NOP, init_busy=1, pred_ready=0, resolve_err=0, stats=0.
- S_INIT: each cycle tbl_we=1, tbl_op=INIT, tbl_idx=sweep_idx, sweep_idx++. After index 2^HIST_W-1 is issued, go to S_RUN next cycle with init_busy=0. The sweep takes exactly 2^HIST_W cycles.
  - pred_valid, resolve_valid and flush are ignored in S_INIT; resolve_err is not raised.
  - Reset mid-sweep restarts the sweep at 0.
- S_RUN, pred_ready = !full (combinational from the count register). Push {pred_hist, lp_pred, gp_pred} when pred_valid && pred_ready.
- Resolve in S_RUN with FIFO non-empty pops the head. Let lp_ok = (lp_pred == resolve_taken) and gp_ok = (gp_pred == resolve_taken).
  - gp_ok && !lp_ok: op = INC.
  - lp_ok && !gp_ok: op = DEC.
  - Otherwise: tbl_we=0, op = NOP.
  - Outputs are registered: tbl_we/idx/op are valid the cycle after resolve_valid (1-cycle latency).
  - Saturation (0 / 2^CTR_W-1) is applied by the table, not the controller.
- Resolve with FIFO empty: no pop, no update, resolve_err=1 for one cycle.
- Simultaneous push and pop: count unchanged, both performed. When full, a push is rejected even if a pop occurs in the same cycle.
- flush: the same-cycle resolve is processed first (head update issued), then the FIFO is emptied (pointers and count set to 0). A same-cycle push is discarded.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- tbl_we=0 in any S_RUN cycle that has no qualifying update.

Optional Feature:
- Macro CHOICE_STATS_EN.
- Defined: stat_gp_wins / stat_lp_wins count INC / DEC updates issued. Both are 16-bit and saturate at 16'hFFFF. Cleared by reset, not by flush.
- Undefined: both ports are driven constant 0 and no counter flops are built.

Decomposition:
- Package tournament_pkg:
  - tbl_op_e enum (NOP/INC/DEC/INIT).
  - inflight_t struct {hist, lp, gp}.
  - Function choice_init_val(CTR_W).
- Sub-module tournament_inflight_fifo (parameterised DEPTH, payload inflight_t) provides push/pop/flush, full/empty and head. The FSM and update logic stay in choice_update_ctrl.

Test Plan:
- Reset, HIST_W=4: 16 consecutive cycles of tbl_we=1, op=INIT, idx 0..15; init_busy drops the next cycle and pred_ready=1. Assert reset at idx=7 -> sweep restarts at idx 0.
- Push hist=12'h0A5, lp=1, gp=0; resolve_taken=0 -> next cycle tbl_we=1, idx=12'h0A5, op=INC. Same entry resolved taken=1 -> op=DEC. Push lp=gp=1 -> tbl_we=0.
- Push DEPTH=4 entries -> pred_ready=0 and a 5th pred_valid is ignored. Resolve 4 times -> updates appear in push order; pred_ready returns 1 after the first pop.
- Resolve with empty FIFO -> resolve_err pulse, tbl_we=0. Simultaneous push+resolve at count=2 -> count stays 2 and the head update is issued.
- 3 entries in flight, flush asserted together with resolve_valid -> the head's update is issued, FIFO is empty next cycle, and a following resolve raises resolve_err.
- With CHOICE_STATS_EN: 3 INC + 2 DEC -> stat_gp_wins=3, stat_lp_wins=2. Without the macro both read 0.
